// File: rtl/systolic_seq_top.sv
// systolic_seq_top: sequencer for an external N x N weight-stationary systolic array.
// Keeps host-visible A, B and C buffers, preloads B rows into the array, streams
// diagonally skewed A columns, and captures C from the bottom partial-sum lanes.
// Ports:
//   Clock, rst            single clock, synchronous active-high reset
//   start, busy, done     run request / in-progress flag / completion pulse
//   host_we/re/addr/wdata host access: B at 0.., A at N*N.., C at 2*N*N..
//   host_rdata/rvalid/err registered read data, read strobe echo, access error pulse
//   arr_*                 array controls and lane-packed data (lane i at [i*DW +: DW])
module systolic_seq_top #(
  parameter int unsigned N       = 4,
  parameter int unsigned DW      = 16,
  parameter int unsigned OUT_LAT = 4,
  parameter int unsigned AW      = 6
) (
  input  logic            Clock,
  input  logic            rst,
  input  logic            start,
  output logic            busy,
  output logic            done,
  input  logic            host_we,
  input  logic            host_re,
  input  logic [AW-1:0]   host_addr,
  input  logic [DW-1:0]   host_wdata,
  output logic [DW-1:0]   host_rdata,
  output logic            host_rvalid,
  output logic            host_err,
  output logic            arr_data_clear,
  output logic            arr_en_b_shift_bottom,
  output logic            arr_en_shift_right,
  output logic            arr_en_shift_bottom,
  output logic [N*DW-1:0] arr_a_left_flat,
  output logic [N*DW-1:0] arr_b_top_flat,
  output logic [N*DW-1:0] arr_ps_top_flat,
  input  logic [N*DW-1:0] arr_ps_bottom_flat
);

  localparam int unsigned NN = N * N;
  localparam int unsigned L  = 2 * N - 1 + OUT_LAT;
  localparam int unsigned CW = $clog2(L + 1);
  localparam int unsigned IW = (NN > 1) ? $clog2(NN) : 1;
  localparam int unsigned LW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {IDLE, CLEAR, LOADB, STREAM, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;

  logic [DW-1:0] a_mem [NN];
  logic [DW-1:0] b_mem [NN];
  logic [DW-1:0] c_mem [NN];

  logic [DW-1:0] a_left_q   [N];
  logic [DW-1:0] b_top_q    [N];
  logic [DW-1:0] a_left_nxt [N];
  logic [DW-1:0] b_top_nxt  [N];
  logic [DW-1:0] ps_lane    [N];

  logic busy_nxt, done_nxt, clear_nxt, en_b_nxt, en_s_nxt;

  // Next state and phase counter.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = CLEAR;
          cnt_nxt   = '0;
        end
      end
      CLEAR: begin
        state_nxt = LOADB;
        cnt_nxt   = '0;
      end
      LOADB: begin
        if (cnt == CW'(N - 1)) begin
          state_nxt = STREAM;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      STREAM: begin
        if (cnt == CW'(L - 1)) begin
          state_nxt = DONE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      DONE: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs are decoded from the upcoming state so the registered values line up
  // with the state they belong to.
  always_comb begin
    busy_nxt  = (state_nxt != IDLE);
    done_nxt  = (state_nxt == DONE);
    clear_nxt = (state_nxt == CLEAR);
    en_b_nxt  = (state_nxt == LOADB);
    en_s_nxt  = (state_nxt == STREAM);
    for (int unsigned i = 0; i < N; i++) begin
      a_left_nxt[LW'(i)] = '0;
      b_top_nxt[LW'(i)]  = '0;
    end
    // B rows enter bottom-row first so row k ends up in array row k.
    if (state_nxt == LOADB) begin
      for (int unsigned j = 0; j < N; j++)
        b_top_nxt[LW'(j)] = b_mem[IW'((N - 1 - 32'(cnt_nxt)) * N + j)];
    end
    // Lane i carries column i of A delayed by i cycles.
    if (state_nxt == STREAM) begin
      for (int unsigned i = 0; i < N; i++)
        if ((32'(cnt_nxt) >= i) && (32'(cnt_nxt) - i < N))
          a_left_nxt[LW'(i)] = a_mem[IW'((32'(cnt_nxt) - i) * N + i)];
    end
  end

  // State register and registered array-side outputs.
  always_ff @(posedge Clock) begin
    if (rst) begin
      state                 <= IDLE;
      cnt                   <= '0;
      busy                  <= 1'b0;
      done                  <= 1'b0;
      arr_data_clear        <= 1'b0;
      arr_en_b_shift_bottom <= 1'b0;
      arr_en_shift_right    <= 1'b0;
      arr_en_shift_bottom   <= 1'b0;
      a_left_q              <= '{default: '0};
      b_top_q               <= '{default: '0};
    end else begin
      state                 <= state_nxt;
      cnt                   <= cnt_nxt;
      busy                  <= busy_nxt;
      done                  <= done_nxt;
      arr_data_clear        <= clear_nxt;
      arr_en_b_shift_bottom <= en_b_nxt;
      arr_en_shift_right    <= en_s_nxt;
      arr_en_shift_bottom   <= en_s_nxt;
      a_left_q              <= a_left_nxt;
      b_top_q               <= b_top_nxt;
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_lane
    assign arr_a_left_flat[g*DW +: DW] = a_left_q[g];
    assign arr_b_top_flat[g*DW +: DW]  = b_top_q[g];
    assign ps_lane[g]                  = arr_ps_bottom_flat[g*DW +: DW];
  end

  assign arr_ps_top_flat = '0;

  // Host address decode.
  logic [31:0]   addr32;
  logic          in_b, in_a, in_c, wr_ok, acc_err;
  logic [DW-1:0] rd_val;

  assign addr32  = 32'(host_addr);
  assign in_b    = (addr32 < NN);
  assign in_a    = (addr32 >= NN) && (addr32 < 2 * NN);
  assign in_c    = (addr32 >= 2 * NN) && (addr32 < 3 * NN);
  assign wr_ok   = host_we && (state == IDLE) && (in_a || in_b);
  assign acc_err = (host_we && !wr_ok) || (host_re && !(in_a || in_b || in_c));

  always_comb begin
    rd_val = '0;
    if (in_b)      rd_val = b_mem[IW'(addr32)];
    else if (in_a) rd_val = a_mem[IW'(addr32 - NN)];
    else if (in_c) rd_val = c_mem[IW'(addr32 - 2 * NN)];
  end

  // Buffers, host responses and C capture.
  always_ff @(posedge Clock) begin
    if (rst) begin
      a_mem       <= '{default: '0};
      b_mem       <= '{default: '0};
      c_mem       <= '{default: '0};
      host_rdata  <= '0;
      host_rvalid <= 1'b0;
      host_err    <= 1'b0;
    end else begin
      host_rvalid <= host_re;
      host_err    <= acc_err;
      if (host_re) host_rdata <= rd_val;
      if (wr_ok && in_b) b_mem[IW'(addr32)] <= host_wdata;
      if (wr_ok && in_a) a_mem[IW'(addr32 - NN)] <= host_wdata;
      // Row r of column j leaves the array OUT_LAT cycles after its skewed start.
      if (state == STREAM) begin
        for (int unsigned j = 0; j < N; j++)
          if ((32'(cnt) >= j + OUT_LAT) && (32'(cnt) - j - OUT_LAT < N))
            c_mem[IW'((32'(cnt) - j - OUT_LAT) * N + j)] <= ps_lane[LW'(j)];
      end
    end
  end

endmodule
